// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage core's pipeline sequencing logic:
// FSM encodings, datapath widths and the bundle of per-stage control outputs.
package pipe_pkg;

  localparam int REG_ADDR_W  = 3;
  localparam int DATA_W      = 16;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_IMISS = 2'd2,
    ST_DMISS = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
  } ctrl_t;

  // Canonical control patterns, one per pipeline situation.
  localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_IMISS    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard comparator: a load in ID_EX whose destination feeds a
// source operand of the instruction waiting in IF_ID.
module pipe_hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ifid_rs_i,
  input  logic [REG_ADDR_W-1:0] ifid_rt_i,
  input  logic                  ifid_use_rt_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  output logic                  load_use_o
);

  logic rs_match;
  logic rt_match;

  // Register 0 is compared like any other; a spurious stall is harmless.
  assign rs_match   = (idex_rt_i == ifid_rs_i);
  assign rt_match   = ifid_use_rt_i && (idex_rt_i == ifid_rt_i);
  assign load_use_o = idex_mem_read_i && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: arbitrates data-miss, taken-branch, load-use
// and instruction-miss stalls into per-stage enables and flush/bubble controls.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int P_BR_PENALTY   = 2,
  parameter int P_MISS_TIMEOUT = 255
) (
  input  logic                   inp_clk,
  input  logic                   inp_rstn,
  input  logic [REG_ADDR_W-1:0]  inp_ifid_rs,
  input  logic [REG_ADDR_W-1:0]  inp_ifid_rt,
  input  logic                   inp_ifid_useRt,
  input  logic                   inp_idex_memRead,
  input  logic [REG_ADDR_W-1:0]  inp_idex_rt,
  input  logic                   inp_branch_taken,
  input  logic                   inp_imem_hit,
  input  logic                   inp_dmem_req,
  input  logic                   inp_dmem_hit,
  output logic                   out_pc_en,
  output logic                   out_ifid_en,
  output logic                   out_ifid_flush,
  output logic                   out_idex_en,
  output logic                   out_idex_bubble,
  output logic                   out_exmem_en,
  output logic                   out_memwb_en,
  output logic [1:0]             out_state,
  output logic [STALL_CNT_W-1:0] out_stall_cnt,
  output logic                   out_err
);

  localparam logic [3:0]  FLUSH_LOAD = 4'(P_BR_PENALTY - 1);
  localparam logic [15:0] TIMEOUT    = 16'(P_MISS_TIMEOUT);

  state_e                 state_q, state_d;
  state_e                 saved_q, saved_d;
  state_e                 eff_state;
  logic [3:0]             flush_cnt_q, flush_cnt_d;
  logic [15:0]            wait_cnt_q, wait_cnt_d;
  logic [15:0]            wait_inc;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   err_q, err_d;
  logic                   dmiss;
  logic                   load_use;
  ctrl_t                  ctrl;

  pipe_hazard_detect u_detect (
    .ifid_rs_i       (inp_ifid_rs),
    .ifid_rt_i       (inp_ifid_rt),
    .ifid_use_rt_i   (inp_ifid_useRt),
    .idex_mem_read_i (inp_idex_memRead),
    .idex_rt_i       (inp_idex_rt),
    .load_use_o      (load_use)
  );

  assign dmiss = inp_dmem_req && !inp_dmem_hit;

  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    ctrl        = CTRL_RUN;
    eff_state   = state_q;
    // Frozen cycles counted so far, including the one being decided now.
    wait_inc    = ((state_q == ST_DMISS) ? wait_cnt_q : 16'd0) + 16'd1;

    if (dmiss) begin
      ctrl = CTRL_FREEZE;
      if (state_q != ST_DMISS) saved_d = state_q;
      if (wait_inc >= TIMEOUT) begin
        err_d       = 1'b1;
        state_d     = ST_RUN;
        wait_cnt_d  = '0;
        flush_cnt_d = '0;
      end else begin
        state_d    = ST_DMISS;
        wait_cnt_d = wait_inc;
      end
    end else begin
      // A completed data access resumes whatever the freeze interrupted.
      wait_cnt_d = '0;
      eff_state  = (state_q == ST_DMISS) ? saved_q : state_q;
      state_d    = eff_state;
      if (inp_branch_taken) begin
        ctrl = CTRL_FLUSH;
        if (P_BR_PENALTY > 1) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        unique case (eff_state)
          ST_FLUSH: begin
            ctrl = CTRL_FLUSH;
            if (flush_cnt_q <= 4'd1) begin
              state_d     = ST_RUN;
              flush_cnt_d = '0;
            end else begin
              flush_cnt_d = flush_cnt_q - 4'd1;
            end
          end
          ST_RUN: begin
            if (load_use) begin
              ctrl = CTRL_LOAD_USE;
            end else if (!inp_imem_hit) begin
              ctrl    = CTRL_IMISS;
              state_d = ST_IMISS;
            end
          end
          ST_IMISS: begin
            if (!inp_imem_hit) ctrl = CTRL_IMISS;
            else               state_d = ST_RUN;
          end
          default: state_d = ST_RUN;
        endcase
      end
    end

    if (!inp_rstn) ctrl = CTRL_RESET;
  end

  // NOTE: synchronous reset, and non-blocking assignments so every register
  // samples the pre-edge value of every other.
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      state_q     <= ST_RUN;
      saved_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      if (!ctrl.pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign out_pc_en       = ctrl.pc_en;
  assign out_ifid_en     = ctrl.ifid_en;
  assign out_ifid_flush  = ctrl.ifid_flush;
  assign out_idex_en     = ctrl.idex_en;
  assign out_idex_bubble = ctrl.idex_bubble;
  assign out_exmem_en    = ctrl.exmem_en;
  assign out_memwb_en    = ctrl.memwb_en;
  assign out_state       = state_q;
  assign out_stall_cnt   = stall_cnt_q;
  assign out_err         = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle model queues the expected
// outputs for each applied vector; they are compared at the following negedge.
module tb_pipe_hazard_ctrl;

  localparam int BR_PEN  = 2;
  localparam int TIMEOUT = 8;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}
  localparam logic [6:0] E_RUN    = 7'b1101011;
  localparam logic [6:0] E_RESET  = 7'b0010100;
  localparam logic [6:0] E_FREEZE = 7'b0000000;
  localparam logic [6:0] E_FLUSH  = 7'b1111111;
  localparam logic [6:0] E_LU     = 7'b0001111;
  localparam logic [6:0] E_IMISS  = 7'b0111011;

  typedef struct {
    bit         rstn;
    logic [2:0] rs, rt, idex_rt;
    bit         use_rt, mem_read, branch, imem_hit, dmem_req, dmem_hit;
  } vec_t;

  typedef struct {
    logic [6:0]  ctrl;
    logic [1:0]  state;
    logic [15:0] stall;
    logic        err;
    bit          known;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [2:0]  ifid_rs, ifid_rt, idex_rt;
  logic        ifid_use_rt, idex_mem_read, branch_taken, imem_hit, dmem_req, dmem_hit;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];

  // Reference model state
  int m_state = 0, m_saved = 0, m_fcnt = 0, m_wcnt = 0, m_stall = 0;
  bit m_err = 0, m_known = 0;

  pipe_hazard_ctrl #(.P_BR_PENALTY(BR_PEN), .P_MISS_TIMEOUT(TIMEOUT)) dut (
    .inp_clk          (clk),
    .inp_rstn         (rstn),
    .inp_ifid_rs      (ifid_rs),
    .inp_ifid_rt      (ifid_rt),
    .inp_ifid_useRt   (ifid_use_rt),
    .inp_idex_memRead (idex_mem_read),
    .inp_idex_rt      (idex_rt),
    .inp_branch_taken (branch_taken),
    .inp_imem_hit     (imem_hit),
    .inp_dmem_req     (dmem_req),
    .inp_dmem_hit     (dmem_hit),
    .out_pc_en        (pc_en),
    .out_ifid_en      (ifid_en),
    .out_ifid_flush   (ifid_flush),
    .out_idex_en      (idex_en),
    .out_idex_bubble  (idex_bubble),
    .out_exmem_en     (exmem_en),
    .out_memwb_en     (memwb_en),
    .out_state        (state),
    .out_stall_cnt    (stall_cnt),
    .out_err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v.rstn = 1; v.rs = 3'd1; v.rt = 3'd2; v.idex_rt = 3'd5;
    v.use_rt = 0; v.mem_read = 0; v.branch = 0;
    v.imem_hit = 1; v.dmem_req = 0; v.dmem_hit = 0;
    return v;
  endfunction

  // Apply one vector for one clock: model predicts, DUT is compared at negedge.
  task automatic step(input vec_t v);
    exp_t e;
    int   nx_state, nx_saved, nx_fcnt, nx_wcnt, nx_stall, cur, frozen;
    bit   nx_err, dmiss, lu;

    rstn = v.rstn; ifid_rs = v.rs; ifid_rt = v.rt; idex_rt = v.idex_rt;
    ifid_use_rt = v.use_rt; idex_mem_read = v.mem_read; branch_taken = v.branch;
    imem_hit = v.imem_hit; dmem_req = v.dmem_req; dmem_hit = v.dmem_hit;

    e.state = 2'(m_state); e.stall = 16'(m_stall); e.err = m_err; e.known = m_known;
    nx_state = m_state; nx_saved = m_saved; nx_fcnt = m_fcnt;
    nx_wcnt = m_wcnt; nx_stall = m_stall; nx_err = m_err;

    if (!v.rstn) begin
      e.ctrl = E_RESET;
      nx_state = 0; nx_saved = 0; nx_fcnt = 0; nx_wcnt = 0; nx_stall = 0; nx_err = 0;
    end else begin
      dmiss = v.dmem_req && !v.dmem_hit;
      lu = v.mem_read && ((v.idex_rt == v.rs) || (v.use_rt && (v.idex_rt == v.rt)));
      if (dmiss) begin
        e.ctrl = E_FREEZE;
        frozen = (m_state == 3) ? m_wcnt + 1 : 1;
        if (m_state != 3) nx_saved = m_state;
        if (frozen >= TIMEOUT) begin
          nx_err = 1; nx_state = 0; nx_wcnt = 0; nx_fcnt = 0;
        end else begin
          nx_state = 3; nx_wcnt = frozen;
        end
      end else begin
        cur = (m_state == 3) ? m_saved : m_state;
        nx_wcnt = 0;
        if (v.branch) begin
          e.ctrl = E_FLUSH; nx_state = 1; nx_fcnt = BR_PEN - 1;
        end else if (cur == 1) begin
          e.ctrl = E_FLUSH;
          nx_fcnt = m_fcnt - 1;
          nx_state = (nx_fcnt <= 0) ? 0 : 1;
          if (nx_fcnt < 0) nx_fcnt = 0;
        end else if (cur == 0 && lu) begin
          e.ctrl = E_LU; nx_state = 0;
        end else if (!v.imem_hit) begin
          e.ctrl = E_IMISS; nx_state = 2;
        end else begin
          e.ctrl = E_RUN; nx_state = 0;
        end
      end
      if (!e.ctrl[6] && m_stall < 16'hFFFF) nx_stall = m_stall + 1;
    end
    sb_q.push_back(e);

    @(negedge clk);
    e = sb_q.pop_front();
    check("ctrl", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en}),
          32'(e.ctrl));
    if (e.known) begin
      check("state", 32'(state), 32'(e.state));
      check("stall_cnt", 32'(stall_cnt), 32'(e.stall));
      check("err", 32'(err), 32'(e.err));
    end

    @(posedge clk);
    #1;
    m_state = nx_state; m_saved = nx_saved; m_fcnt = nx_fcnt;
    m_wcnt = nx_wcnt; m_stall = nx_stall; m_err = nx_err;
    if (!v.rstn) m_known = 1;
  endtask

  initial begin
    vec_t v;
    #1;

    // Reset for two cycles, then run idle
    v = idle(); v.rstn = 0;
    repeat (2) step(v);
    repeat (2) step(idle());

    // Load-use on rs; then rt with and without useRt; register 0 match
    v = idle(); v.mem_read = 1; v.idex_rt = 3; v.rs = 3;
    step(v); step(idle());
    v = idle(); v.mem_read = 1; v.idex_rt = 6; v.rt = 6; v.use_rt = 1;
    step(v);
    v.use_rt = 0;
    step(v);
    v = idle(); v.mem_read = 1; v.idex_rt = 0; v.rs = 0;
    step(v); step(idle());

    // Taken branch: two flush cycles, back to RUN
    v = idle(); v.branch = 1;
    step(v); repeat (2) step(idle());

    // Branch reloads while already flushing
    step(v); step(v); repeat (2) step(idle());

    // Five-cycle data miss, then hit
    v = idle(); v.dmem_req = 1;
    repeat (5) step(v);
    v.dmem_hit = 1;
    step(v); step(idle());

    // Data miss arriving mid-flush resumes the flush afterwards
    v = idle(); v.branch = 1; step(v);
    v = idle(); v.dmem_req = 1;
    repeat (3) step(v);
    repeat (2) step(idle());

    // Branch and load-use together: branch wins
    v = idle(); v.branch = 1; v.mem_read = 1; v.idex_rt = 4; v.rs = 4;
    step(v); repeat (2) step(idle());

    // Instruction miss for three cycles
    v = idle(); v.imem_hit = 0;
    repeat (3) step(v);
    step(idle());

    // Data miss held past the timeout; err stays until reset
    v = idle(); v.dmem_req = 1;
    repeat (10) step(v);
    repeat (3) step(idle());
    v = idle(); v.rstn = 0;
    step(v);
    repeat (2) step(idle());

    // Reset abandoning an instruction miss
    v = idle(); v.imem_hit = 0;
    repeat (2) step(v);
    v.rstn = 0; step(v);
    step(idle());

    // Random traffic with frequent register matches
    for (int i = 0; i < 300; i++) begin
      v.rstn     = ($urandom_range(0, 49) != 0);
      v.rs       = 3'($urandom_range(0, 3));
      v.rt       = 3'($urandom_range(0, 3));
      v.idex_rt  = 3'($urandom_range(0, 3));
      v.use_rt   = 1'($urandom_range(0, 1));
      v.mem_read = ($urandom_range(0, 9) < 4);
      v.branch   = ($urandom_range(0, 9) < 2);
      v.imem_hit = ($urandom_range(0, 9) < 8);
      v.dmem_req = ($urandom_range(0, 9) < 3);
      v.dmem_hit = ($urandom_range(0, 9) < 4);
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
